// File: rtl/ip_ram_16x16.sv
// ============================================================================
// Module   : ip_ram_16x16
// Purpose  : 16x16 single-port synchronous RAM with registered read port and
//            asynchronous clear of array and read register.
// Options  : IP_RAM_WRITE_FIRST_EN - echo write data on ram_rd_data
//            (default: read register holds on writes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ip_ram_16x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,   // active-high despite the name
  input  logic              ram_en,
  input  logic              ram_wea,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  output logic [DATA_W-1:0] ram_rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;

  logic        w_wr;
  logic        w_rd;
  logic        w_in_range;
  logic [31:0] w_addr_ext;

  assign w_addr_ext = 32'(ram_addr);
  // Only meaningful when DEPTH is smaller than the address space.
  assign w_in_range = (w_addr_ext < 32'(DEPTH));
  assign w_wr       = ram_en &  ram_wea;
  assign w_rd       = ram_en & ~ram_wea;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (w_wr && w_in_range) begin
      mem_d[ram_addr] = ram_wr_data;
    end
  end

  always_comb begin
    rd_d = rd_q;
    if (w_rd) begin
      rd_d = w_in_range ? mem_q[ram_addr] : '0;
    end
`ifdef IP_RAM_WRITE_FIRST_EN
    else if (w_wr) begin
      rd_d = ram_wr_data;
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_q <= rd_d;
    end
  end

  assign ram_rd_data = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_ip_ram_16x16.sv
// ============================================================================
// Module   : tb_ip_ram_16x16
// Purpose  : Self-checking bench for ip_ram_16x16 against an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ip_ram_16x16;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              ram_en    = 1'b0;
  logic              ram_wea   = 1'b0;
  logic [ADDR_W-1:0] ram_addr  = '0;
  logic [DATA_W-1:0] ram_wr_data = '0;
  logic [DATA_W-1:0] ram_rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd;

  ip_ram_16x16 #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .ram_en     (ram_en),
    .ram_wea    (ram_wea),
    .ram_addr   (ram_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference: plain array plus the last value the read port must show.
  always @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      foreach (m_mem[i]) m_mem[i] <= '0;
      m_rd <= '0;
    end else if (ram_en) begin
      if (ram_wea) begin
        m_mem[ram_addr] <= ram_wr_data;
`ifdef IP_RAM_WRITE_FIRST_EN
        m_rd <= ram_wr_data;
`endif
      end else begin
        m_rd <= m_mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cmp_en) check("model_cmp", ram_rd_data, m_rd);
  end

  // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
  task automatic op(input bit en, input bit we, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    ram_en      = en;
    ram_wea     = we;
    ram_addr    = a;
    ram_wr_data = d;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    #1 sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("reset_rd", ram_rd_data, 16'h0000);
    sys_rst_n = 1'b0;
    cmp_en    = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom));
      check("post_reset_read", ram_rd_data, 16'h0000);
    end

    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b1, ADDR_W'(i), 16'hA500 + 16'(i));
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, ADDR_W'(i), 16'h0000);
      check("sweep_read", ram_rd_data, 16'hA500 + 16'(i));
      check("model_pin", m_rd, 16'hA500 + 16'(i));
    end

    op(1'b1, 1'b0, 4'd3, 16'h0000);
    check("gate_read", ram_rd_data, 16'hA503);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
      check("gate_hold", ram_rd_data, 16'hA503);
    end
    op(1'b1, 1'b0, 4'd3, 16'h0000);
    check("gate_reread", ram_rd_data, 16'hA503);

    op(1'b1, 1'b0, 4'd7, 16'h0000);
    check("wm_read", ram_rd_data, 16'hA507);
    op(1'b1, 1'b1, 4'd7, 16'h1234);
`ifdef IP_RAM_WRITE_FIRST_EN
    check("wm_write_echo", ram_rd_data, 16'h1234);
`else
    check("wm_write_hold", ram_rd_data, 16'hA507);
`endif
    op(1'b1, 1'b0, 4'd7, 16'h0000);
    check("wm_raw", ram_rd_data, 16'h1234);

    for (int i = 0; i < 3; i++) op(1'b1, 1'b1, ADDR_W'($urandom), 16'h8000 | DATA_W'($urandom));
    ram_en      = 1'b1;
    ram_wea     = 1'b1;
    ram_addr    = 4'd5;
    ram_wr_data = 16'h5A5A;
    #2 sys_rst_n = 1'b1;
    #1 check("async_rst_rd", ram_rd_data, 16'h0000);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, ADDR_W'(i), 16'h0000);
      check("after_rst_read", ram_rd_data, 16'h0000);
    end

    op(1'b1, 1'b1, 4'd0,  16'hFFFF);
    op(1'b1, 1'b1, 4'd15, 16'h8001);
    op(1'b1, 1'b0, 4'd0,  16'h0000); check("bound_addr0",  ram_rd_data, 16'hFFFF);
    op(1'b1, 1'b0, 4'd15, 16'h0000); check("bound_addr15", ram_rd_data, 16'h8001);
    op(1'b1, 1'b0, 4'd1,  16'h0000); check("bound_addr1",  ram_rd_data, 16'h0000);
    op(1'b1, 1'b0, 4'd14, 16'h0000); check("bound_addr14", ram_rd_data, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      v = DATA_W'($urandom);
      op(($urandom_range(0, 3) != 0), 1'($urandom), ADDR_W'($urandom), v);
    end
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 1'b0, ADDR_W'(i), 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ip_ram_16x16.md
Name: ip_ram_16x16

Overview:
Single-port synchronous RAM with 16 words of 16 bits and a registered read port, matching the ip_ram interface.
Serves as the CPU's scratch data memory.
Writes commit on the clock edge.
Reads return data one cycle after the request.
Reset clears the whole array and the read register.

Parameters:
DATA_W, 16, word width in bits (ram_wr_data / ram_rd_data)
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; must equal 2**ADDR_W

Ports:
sys_clk  input  1  system clock; all state changes on the rising edge
sys_rst_n  input  1  asynchronous, active-high reset; the _n suffix is kept for codebase naming only, and 1 = reset asserted
ram_en  input  1  port enable; 0 = no read, no write, ram_rd_data holds
ram_wea  input  1  write enable, qualified by ram_en; 1 = write, 0 = read
ram_addr  input  ADDR_W  word address, 0..DEPTH-1
ram_wr_data  input  DATA_W  write data
ram_rd_data  output  DATA_W  registered read data

Behaviour:
- Reset (sys_rst_n=1, async, no clock needed):
  - ram_rd_data = 16'h0000 immediately.
  - All DEPTH words cleared to 0.
  - State holds while reset is asserted; every input is ignored.
  - Deassertion is synchronised by the user; the first active edge is the first rising edge with sys_rst_n=0.
- Idle (ram_en=0):
  - Memory unchanged.
  - ram_rd_data holds its previous value indefinitely.
- Write (ram_en=1, ram_wea=1) at a rising edge:
  - mem[ram_addr] <= ram_wr_data.
  - ram_rd_data behaviour set by the Optional Feature.
- Read (ram_en=1, ram_wea=0) at rising edge N:
  - ram_rd_data <= mem[ram_addr], visible after edge N, i.e. 1-cycle latency.
  - Back-to-back reads to any addresses give one result per cycle, in order.
- Address:
  - Full 4-bit range valid; no wrap logic needed.
  - If DEPTH < 2**ADDR_W, out-of-range writes are dropped and out-of-range reads return 0.
- Read-after-write, same address, next cycle: returns the newly written data.
- Reset mid-operation: a write on the same edge as reset assertion is discarded; the array stays at 0.
- No X propagation: ram_rd_data is never X after the first reset.

Optional Feature:
Macro IP_RAM_WRITE_FIRST_EN.
- Defined (write-first): on a write edge, ram_rd_data <= ram_wr_data, so written data is echoed one cycle later.
- Undefined (default, no-change): on a write edge, ram_rd_data holds its previous value.
- Memory contents are identical in both modes.

Test Plan:
- Reset sequence: sys_rst_n=1 for 4 cycles (Tclk=10 ns), then 0. Read addr 0..15 -> every ram_rd_data = 16'h0000, each 1 cycle after its request.
- Write sweep: write mem[i] = 16'hA500+i for i=0..15, then read 0..15 back-to-back -> ram_rd_data = 16'hA500..16'hA50F on consecutive cycles, 1-cycle latency.
- Enable gating:
  - Read addr 3 (-> 16'hA503).
  - Drop ram_en and toggle addr, wea and wr_data for 5 cycles -> ram_rd_data stays 16'hA503.
  - Re-read addr 3 -> still 16'hA503.
- Write-mode output:
  - Read addr 7 -> 16'hA507.
  - Then write addr 7 = 16'h1234 -> ram_rd_data = 16'h1234 with IP_RAM_WRITE_FIRST_EN, 16'hA507 without.
  - Next-cycle read of addr 7 -> 16'h1234 in both modes.
- Async reset mid-run:
  - Assert sys_rst_n=1 between clock edges during a write burst -> ram_rd_data = 0 before the next edge.
  - After release, reads of all addresses -> 0.
- Boundary addresses: write addr 0 = 16'hFFFF and addr 15 = 16'h8001 -> reads return exactly those values, and addr 1 and addr 14 are unaffected.
